// File: rtl/rv_spi_pkg.sv
// rtl/rv_spi_pkg.sv - shared FSM states and SPI mode encodings for the SPI master
package rv_spi_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    XFER   = 2'd2,
    FINISH = 2'd3
  } spi_state_t;

  // Mode encoding is {cpol, cpha}.
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  // Modes with cpha=0 sample miso on the leading sclk edge, cpha=1 on the trailing edge.
  function automatic logic sample_on_leading(input logic [1:0] mode);
    case (mode)
      MODE0, MODE2: sample_on_leading = 1'b1;
      MODE1, MODE3: sample_on_leading = 1'b0;
      default:      sample_on_leading = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - half-period counter producing one tick every div+1 clocks
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_restart,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;

  assign o_tick = (r_cnt == i_div);

  // Count 0..div, wrapping on tick; restart pins the count to 0 so each state starts a fresh half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - parametrised SPI master with N chip selects, four modes and CS hold
module spi_master_multi
  import rv_spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 2,
  parameter int DIV_W     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic [$clog2(NUM_CS):0] cs_sel,
  input  logic                    hold_cs,
  input  logic                    cs_release,
  input  logic                    cfg_cpol,
  input  logic                    cfg_cpha,
  input  logic [DIV_W-1:0]        cfg_div,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [NUM_CS-1:0]       cs_n
);

  localparam int CS_W   = $clog2(NUM_CS) + 1;
  localparam int EDGE_W = $clog2(2 * DATA_W) + 1;
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  spi_state_t          r_state;
  spi_state_t          w_state_next;
  logic [DATA_W-1:0]   r_tx;
  logic [DATA_W-1:0]   r_rx;
  logic [DATA_W-1:0]   r_rx_data;
  logic [EDGE_W-1:0]   r_edge;
  logic [NUM_CS-1:0]   r_cs_n;
  logic [DIV_W-1:0]    r_div;
  logic                r_cpol;
  logic                r_cpha;
  logic                r_hold;
  logic                r_sclk;
  logic                r_mosi;
  logic                r_done;
  logic                w_tick;
  logic                w_restart;
  logic                w_last_edge;
  logic                w_sample;
  logic                w_drive;

  function automatic logic head_bit(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v);
    return (LSB_FIRST != 0) ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v, input logic b);
    return (LSB_FIRST != 0) ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  // Out-of-range selects decode to all-high so the transfer runs with no device selected.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (int'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_restart (w_restart),
    .i_div     (r_div),
    .o_tick    (w_tick)
  );

  // Edge r_edge+1 is leading when r_edge is even; sample or drive depends on the latched mode.
  assign w_last_edge = (r_edge == LAST_EDGE);
  assign w_sample    = (~r_edge[0]) == sample_on_leading({r_cpol, r_cpha});
  assign w_drive     = !w_sample && !w_last_edge;
  assign w_restart   = (r_state == IDLE) || (w_state_next != r_state);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: each non-idle state advances on a tick; XFER waits for its last edge.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SETUP;
      SETUP:   if (w_tick) w_state_next = XFER;
      XFER:    if (w_tick && w_last_edge) w_state_next = FINISH;
      FINISH:  if (w_tick) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Datapath: latch on accept, toggle sclk and shift on ticks, publish the word in FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_edge    <= '0;
      r_cs_n    <= '1;
      r_div     <= '0;
      r_cpol    <= 1'b0;
      r_cpha    <= 1'b0;
      r_hold    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_div  <= cfg_div;
            r_cpol <= cfg_cpol;
            r_cpha <= cfg_cpha;
            r_hold <= hold_cs;
            r_sclk <= cfg_cpol;
            r_cs_n <= cs_decode(cs_sel);
            r_edge <= '0;
            r_rx   <= '0;
            if (!cfg_cpha) begin
              r_mosi <= head_bit(tx_data);
              r_tx   <= shift_out(tx_data);
            end else begin
              r_tx   <= tx_data;
            end
          end else if (cs_release) begin
            r_cs_n <= '1;
          end
        end
        SETUP: begin
        end
        XFER: begin
          if (w_tick) begin
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + EDGE_W'(1);
            if (w_sample) r_rx <= shift_in(r_rx, miso);
            if (w_drive) begin
              r_mosi <= head_bit(r_tx);
              r_tx   <= shift_out(r_tx);
            end
          end
        end
        FINISH: begin
          if (w_tick) begin
            r_rx_data <= r_rx;
            r_done    <= 1'b1;
            r_mosi    <= 1'b0;
            if (!r_hold) r_cs_n <= '1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != IDLE);
  assign done    = r_done;
  assign rx_data = r_rx_data;
  assign sclk    = r_sclk;
  assign mosi    = r_mosi;
  assign cs_n    = r_cs_n;

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - randomized self-checking bench with a cycle-level SPI transaction model
module tb_spi_master_multi;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = '0;
  logic [1:0] cs_sel = '0;
  logic       hold_cs = 1'b0;
  logic       cs_release = 1'b0;
  logic       cfg_cpol = 1'b0;
  logic       cfg_cpha = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       busy, done, sclk, mosi;
  logic [7:0] rx_data;
  logic [1:0] cs_n;
  logic       miso_drv = 1'b0;
  wire        miso_w;

  // Model state: one transaction at a time, described by its accept cycle and latched settings.
  int         cyc = 0;
  bit         act = 0;
  bit         done_now = 0;
  int         a_cyc = 0;
  int         m_div = 0;
  bit         m_cpol = 0, m_cpha = 0, m_hold = 0, m_loop = 0;
  int         m_sel = 0;
  logic [7:0] m_tx = '0, m_rxw = '0;
  logic [1:0] idle_cs = 2'b11;
  bit         idle_sclk = 0;
  logic [7:0] exp_rx = '0;
  logic [7:0] s_rxw = '0;
  bit         s_loop = 0;

  int pass_cnt = 0, chk_cnt = 0;
  int done_seen = 0, last_done_cyc = 0, rises = 0;
  bit prev_sclk = 0;

  assign miso_w = m_loop ? mosi : miso_drv;

  always #5 clk = ~clk;

  spi_master_multi #(.DATA_W(8), .NUM_CS(2), .DIV_W(8), .LSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tx_data(tx_data), .cs_sel(cs_sel),
    .hold_cs(hold_cs), .cs_release(cs_release), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_div(cfg_div), .busy(busy), .done(done), .rx_data(rx_data), .sclk(sclk),
    .mosi(mosi), .miso(miso_w), .cs_n(cs_n)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    chk_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, got, want, $time);
  endtask

  function automatic logic [1:0] dec(input int s);
    logic [1:0] v;
    v = 2'b11;
    if (s < 2) v[s] = 1'b0;
    return v;
  endfunction

  function automatic int bp(input int idx);
    return W - 1 - idx;
  endfunction

  function automatic int t_done();
    return (m_div + 1) * (2 * W + 2);
  endfunction

  // Model update at each edge: finish, accept or release, in the priority the block defines.
  always @(posedge clk or negedge rst_n) begin : model
    bit was_busy;
    if (!rst_n) begin
      act = 0; done_now = 0; idle_cs = 2'b11; idle_sclk = 0; exp_rx = '0;
    end else begin
      was_busy = act && ((cyc - a_cyc) < t_done());
      cyc++;
      done_now = 0;
      if (act && (cyc - a_cyc) == t_done()) begin
        done_now  = 1;
        exp_rx    = m_loop ? m_tx : m_rxw;
        idle_cs   = m_hold ? dec(m_sel) : 2'b11;
        idle_sclk = m_cpol;
        act       = 0;
      end
      if (!was_busy && start) begin
        act = 1; a_cyc = cyc;
        m_tx = tx_data; m_sel = int'(cs_sel); m_hold = hold_cs;
        m_cpol = cfg_cpol; m_cpha = cfg_cpha; m_div = int'(cfg_div);
        m_rxw = s_rxw; m_loop = s_loop;
      end else if (!was_busy && cs_release) begin
        idle_cs = 2'b11;
      end
    end
  end

  // Every cycle: compare pins against the model, then present the slave's next miso bit.
  always @(negedge clk) begin : cmp
    int t, tg, idx;
    if (rst_n) begin
      if (act) begin
        t  = cyc - a_cyc;
        tg = t / (m_div + 1) - 1;
        if (tg < 0) tg = 0;
        if (tg > 2 * W) tg = 2 * W;
        if (m_cpha == 0) idx = (tg / 2 > W - 1) ? W - 1 : tg / 2;
        else             idx = (tg == 0) ? 0 : (tg - 1) / 2;
        chk("busy", busy, 1);
        chk("sclk", sclk, m_cpol ^ (tg % 2));
        chk("cs_n", cs_n, dec(m_sel));
        if (m_cpha == 0 || tg > 0) chk("mosi", mosi, m_tx[bp(idx)]);
        miso_drv = m_rxw[bp(idx)];
      end else begin
        chk("busy_idle", busy, 0);
        chk("sclk_idle", sclk, idle_sclk);
        chk("cs_n_idle", cs_n, idle_cs);
        chk("mosi_idle", mosi, 0);
      end
      chk("done", done, done_now);
      chk("rx_data", rx_data, exp_rx);
      if (done) begin
        done_seen++;
        last_done_cyc = cyc - a_cyc + 1;
      end
      if (sclk && !prev_sclk) rises++;
      prev_sclk = sclk;
    end
  end

  task automatic start_only(input logic [7:0] tx, input int sel, input bit hold, input bit cpol,
                            input bit cpha, input int div, input logic [7:0] rxw, input bit loop,
                            input bit rel);
    @(negedge clk);
    tx_data = tx; cs_sel = 2'(sel); hold_cs = hold; cfg_cpol = cpol; cfg_cpha = cpha;
    cfg_div = 8'(div); s_rxw = rxw; s_loop = loop; start = 1'b1; cs_release = rel;
    @(negedge clk);
    start = 1'b0; cs_release = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (act && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (act) begin
      chk_cnt++;
      $display("FAIL timeout: transfer still active after %0d cycles, required idle", n);
    end
    @(negedge clk);
  endtask

  task automatic xfer(input logic [7:0] tx, input int sel, input bit hold, input bit cpol,
                      input bit cpha, input int div, input logic [7:0] rxw, input bit loop);
    start_only(tx, sel, hold, cpol, cpha, div, rxw, loop, 1'b0);
    wait_idle();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_rx", rx_data, 0);
    chk("rst_mosi", mosi, 0); chk("rst_cs_n", cs_n, 2'b11); chk("rst_sclk", sclk, 0);
    @(posedge clk); #2 rst_n = 1'b1;

    // 1: mode 0, div 0, loopback.
    rises = 0; done_seen = 0;
    start_only(8'hA5, 0, 0, 0, 0, 0, 8'h00, 1, 0);
    repeat (3) @(negedge clk);
    chk("t1_cs_during", cs_n, 2'b10);
    wait_idle();
    chk("t1_rx", rx_data, 8'hA5);
    chk("t1_done_cycle", last_done_cyc, 19);
    chk("t1_rises", rises, 8);
    chk("t1_cs_after", cs_n, 2'b11);

    // 2: mode 3, div 3, cs 1, slave returns 0x3C.
    xfer(8'h5A, 1, 0, 1, 1, 3, 8'h3C, 0);
    chk("t2_rx", rx_data, 8'h3C);
    chk("t2_done_cycle", last_done_cyc, 73);
    chk("t2_sclk_idle", sclk, 1);

    // 3: held CS across two words.
    done_seen = 0;
    xfer(8'h11, 0, 1, 0, 0, 1, 8'hC3, 0);
    chk("t3_cs_held", cs_n, 2'b10);
    xfer(8'h22, 0, 0, 0, 0, 1, 8'h81, 0);
    chk("t3_cs_released", cs_n, 2'b11);
    chk("t3_dones", done_seen, 2);
    chk("t3_rx", rx_data, 8'h81);

    // 4: start while busy is ignored.
    done_seen = 0;
    start_only(8'h96, 0, 0, 0, 0, 0, 8'h00, 1, 0);
    repeat (4) @(negedge clk);
    tx_data = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("t4_rx", rx_data, 8'h96);
    chk("t4_dones", done_seen, 1);

    // 5: reset mid-transfer.
    done_seen = 0;
    start_only(8'h77, 1, 1, 1, 0, 0, 8'h55, 0, 0);
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_cs_n", cs_n, 2'b11); chk("t5_sclk", sclk, 0); chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_no_done", done_seen, 0);
    xfer(8'h3E, 0, 0, 0, 1, 0, 8'hE7, 0);
    chk("t5_rx_after", rx_data, 8'hE7);

    // 6: out-of-range select, then release of a held CS.
    start_only(8'h4B, 3, 0, 0, 0, 1, 8'h2D, 0, 0);
    repeat (4) @(negedge clk);
    chk("t6_no_cs", cs_n, 2'b11);
    wait_idle();
    chk("t6_rx", rx_data, 8'h2D);
    xfer(8'h66, 1, 1, 0, 1, 0, 8'h99, 0);
    chk("t6_held", cs_n, 2'b01);
    cs_release = 1'b1;
    @(negedge clk);
    cs_release = 1'b0;
    chk("t6_released", cs_n, 2'b11);

    // Randomized transfers with release collisions, busy pokes and idle-time releases.
    for (int k = 0; k < 25; k++) begin
      start_only(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                 1'($urandom), int'($urandom_range(0, 3)), 8'($urandom), 1'b0,
                 ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 20)) @(negedge clk);
        if (act) begin
          tx_data = 8'($urandom); start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
      wait_idle();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        cs_release = 1'b1;
        @(negedge clk);
        cs_release = 1'b0;
      end
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
Parametrised SPI master for the rv32e MCU peripheral bus. It succeeds the fixed 8-bit, two-chip-select, mode-0 SPI port. It adds configurable transfer width, N chip selects, all four CPOL/CPHA modes, a runtime clock divider, MSB/LSB ordering and chip-select hold for multi-word transactions. It sits between the CPU memory-mapped register file and the sclk/mosi/miso/cs pads.

Parameters:
DATA_W, 8, bits per transfer (2..32)
NUM_CS, 2, number of active-low chip selects (1..8)
DIV_W, 8, width of cfg_div
LSB_FIRST, 0, 1 = shift LSB first, 0 = MSB first

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a transfer; accepted only when busy=0
tx_data  in  DATA_W  word to send; latched at accept
cs_sel  in  $clog2(NUM_CS)+1  chip-select index; latched at accept
hold_cs  in  1  keep CS asserted after this transfer; latched at accept
cs_release  in  1  deasserts a held CS; honoured only in IDLE
cfg_cpol  in  1  idle level of sclk; latched at accept
cfg_cpha  in  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at accept
cfg_div  in  DIV_W  half-period = cfg_div+1 clk cycles; latched at accept
busy  out  1  high from the accept edge until done
done  out  1  single-cycle pulse when rx_data is valid
rx_data  out  DATA_W  last received word; held until the next done
sclk  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in; already synchronised externally
cs_n  out  NUM_CS  active-low chip selects, one-hot-low or all high

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: busy=0, done=0, rx_data=0, mosi=0, cs_n all 1, sclk=0, state=IDLE, no held CS. Reset asserted mid-transfer aborts immediately to these values, and no done pulse is generated.
- Pin levels: sclk idles at the latched cpol, or 0 after reset. mosi=0 in IDLE.
- States: IDLE, SETUP, XFER, FINISH.
- Tick: a half-period counter counts 0..div and emits a tick when it reaches div. The counter restarts at every state entry.
- IDLE: on start, latch all inputs, set busy=1 and go to SETUP. If a CS is held and the latched cs_sel differs, deassert the held CS on the accept edge.
- SETUP (1 half-period):
  - Assert cs_n[cs_sel] low. If cs_sel ≥ NUM_CS, no CS is asserted but the transfer still runs.
  - If cpha=0, drive the first data bit on mosi.
  - On tick, go to XFER.
- XFER: 2*DATA_W sclk edges, one per tick.
  - Edges 1,3,5,… are leading; edges 2,4,… are trailing.
  - cpha=0: sample miso on leading edges; shift the next bit onto mosi on trailing edges (no shift after the last edge).
  - cpha=1: drive a bit on leading edges; sample miso on trailing edges.
  - After edge 2*DATA_W, sclk has returned to cpol. Go to FINISH.
- FINISH (1 half-period): on tick, update rx_data, pulse done for one cycle, set busy=0 and go to IDLE. Then deassert CS unless hold_cs was latched.
- Latency: done is high in cycle (2*DATA_W+2)*(cfg_div+1)+1 after the accept edge, counting the accept edge as 0. With DATA_W=8 and div=0, that is cycle 19.
- Bit order: LSB_FIRST selects both transmit order and receive assembly.
- start while busy=1 is ignored. cs_release while busy is ignored.
- start and cs_release in the same IDLE cycle: start wins and the release is dropped.
- cs_release with no CS held has no effect.

Decomposition:
- Package rv_spi_pkg: state enum (IDLE/SETUP/XFER/FINISH) and constants for mode encoding {cpol,cpha} MODE0..MODE3.
- Sub-module spi_clk_div: half-period counter with restart input and tick output, parametrised by DIV_W.
- Shift/edge logic and FSM stay in spi_master_multi.

Test Plan:
1. Mode 0, div=0, cs_sel=0, tx 0xA5, miso looped to mosi → cs_n=2'b10 during transfer, 8 rising sclk edges, rx_data=0xA5, done at cycle 19, cs_n=2'b11 afterwards.
2. Mode 3, div=3, cs_sel=1, tx 0x5A, bench drives miso bits of 0x3C on leading edges → sclk idles 1, half-period 4 clks, rx_data=0x3C, done at cycle 73.
3. hold_cs=1 with tx 0x11 then a second start with hold_cs=0 and tx 0x22 on cs_sel=0 → cs_n[0] stays low across both words, goes high after the second done, two done pulses seen.
4. start pulsed again at cycle 5 of a busy transfer with tx 0xFF → ignored, rx/mosi follow the first word only, one done pulse.
5. rst_n low at cycle 10 of a transfer → cs_n all 1, sclk=0, busy=0 immediately, no done pulse; a new transfer afterwards completes normally.
6. cs_sel=3 with NUM_CS=2, plus cs_release while a CS is held in IDLE → the transfer runs with cs_n=2'b11 throughout, and the held CS deasserts on the cycle after cs_release.
